// File: rtl/sram_ctrl_if.sv
// Memory-access bus between the MM stage (master) and the SRAM responder (slave).
interface sram_ctrl_if;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_access_data_o;
    logic        mem_access_read;
    logic        mem_access_write;
    logic [3:0]  mem_access_byte_en;
    logic [31:0] mem_access_data_i;
    logic        stall;

    modport master (
        output mem_access_addr,
        output mem_access_data_o,
        output mem_access_read,
        output mem_access_write,
        output mem_access_byte_en,
        input  mem_access_data_i,
        input  stall
    );

    modport slave (
        input  mem_access_addr,
        input  mem_access_data_o,
        input  mem_access_read,
        input  mem_access_write,
        input  mem_access_byte_en,
        output mem_access_data_i,
        output stall
    );
endinterface

// File: rtl/sram_ctrl.sv
// Responder that runs one MM-stage read or write per transaction on an
// asynchronous 32-bit SRAM, with programmable read/write wait states.
// All SRAM-side outputs are registered so they only move at clock edges.
module sram_ctrl #(
    parameter int unsigned READ_WAIT  = 2,
    parameter int unsigned WRITE_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sram_ctrl_if.slave  bus,
    output logic [19:0] sram_addr,
    output logic [31:0] dq_o,
    output logic        dq_oe,
    input  logic [31:0] dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [3:0]  sram_be_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        WHOLD,
        DONE
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] rdata_q;

    logic        rd_accept;
    logic        wr_accept;
    logic        rd_capture;

    logic        ce_n_next;
    logic        oe_n_next;
    logic        we_n_next;
    logic        dq_oe_next;
    logic [3:0]  be_n_next;

    logic        unused_addr_bits;

    // A read takes priority over a simultaneous write; requests are only looked at in IDLE.
    assign rd_accept  = (state == IDLE) && bus.mem_access_read;
    assign wr_accept  = (state == IDLE) && !bus.mem_access_read && bus.mem_access_write;
    assign rd_capture = (state == RD) && (cnt == 4'd0);

    assign bus.mem_access_data_i = rdata_q;
    assign bus.stall = rst_n &&
                       (((state != IDLE) && (state != DONE)) ||
                        ((state == IDLE) && (bus.mem_access_read || bus.mem_access_write)));

    assign unused_addr_bits = ^{bus.mem_access_addr[31:22], bus.mem_access_addr[1:0]};

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state and wait-counter sequencing of a single transaction.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.mem_access_read) begin
                    state_next = RD;
                    cnt_next   = RD_LOAD;
                end else if (bus.mem_access_write) begin
                    state_next = WSETUP;
                end
            end
            RD: begin
                if (cnt == 4'd0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            WSETUP: begin
                cnt_next   = WR_LOAD;
                state_next = WPULSE;
            end
            WPULSE: begin
                if (cnt == 4'd0) begin
                    state_next = WHOLD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            WHOLD:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobe levels for the state being entered, so the registered pins match the state.
    always_comb begin
        ce_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        we_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        be_n_next  = sram_be_n;
        case (state_next)
            RD: begin
                ce_n_next = 1'b0;
                oe_n_next = 1'b0;
                be_n_next = 4'b0000;
            end
            WSETUP: begin
                ce_n_next  = 1'b0;
                dq_oe_next = 1'b1;
                be_n_next  = ~bus.mem_access_byte_en;
            end
            WPULSE: begin
                ce_n_next  = 1'b0;
                we_n_next  = 1'b0;
                dq_oe_next = 1'b1;
            end
            WHOLD: begin
                ce_n_next  = 1'b0;
                dq_oe_next = 1'b1;
            end
            default: begin
                be_n_next = 4'b1111;
            end
        endcase
    end

    // Registered SRAM strobes; reset drops them at once, even mid-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'b1111;
            dq_oe     <= 1'b0;
        end else begin
            sram_ce_n <= ce_n_next;
            sram_oe_n <= oe_n_next;
            sram_we_n <= we_n_next;
            sram_be_n <= be_n_next;
            dq_oe     <= dq_oe_next;
        end
    end

    // Address/write-data latched on acceptance; read data captured at the end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr <= 20'd0;
            dq_o      <= 32'd0;
            rdata_q   <= 32'd0;
        end else begin
            if (rd_accept || wr_accept) begin
                sram_addr <= bus.mem_access_addr[21:2];
            end
            if (wr_accept) begin
                dq_o <= bus.mem_access_data_o;
            end
            if (rd_capture) begin
                rdata_q <= dq_i;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a default-timing instance and a
// READ_WAIT=1 / WRITE_WAIT=3 instance, each with a small SRAM model.
module tb_sram_ctrl;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    sram_ctrl_if bus0 ();
    sram_ctrl_if bus1 ();

    logic [19:0] sram_addr0, sram_addr1;
    logic [31:0] dq_o0, dq_o1, dq_i0, dq_i1;
    logic        dq_oe0, dq_oe1;
    logic        ce_n0, ce_n1, oe_n0, oe_n1, we_n0, we_n1;
    logic [3:0]  be_n0, be_n1;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    int          m_stall, m_oe, m_we, m_dqoe, m_be_bad;
    logic [19:0] m_addr;
    logic [31:0] m_dq;
    logic [31:0] m_data_done;
    logic        m_timeout;

    sram_ctrl dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus0.slave),
        .sram_addr (sram_addr0),
        .dq_o      (dq_o0),
        .dq_oe     (dq_oe0),
        .dq_i      (dq_i0),
        .sram_ce_n (ce_n0),
        .sram_oe_n (oe_n0),
        .sram_we_n (we_n0),
        .sram_be_n (be_n0)
    );

    sram_ctrl #(.READ_WAIT(1), .WRITE_WAIT(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1.slave),
        .sram_addr (sram_addr1),
        .dq_o      (dq_o1),
        .dq_oe     (dq_oe1),
        .dq_i      (dq_i1),
        .sram_ce_n (ce_n1),
        .sram_oe_n (oe_n1),
        .sram_we_n (we_n1),
        .sram_be_n (be_n1)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous SRAM models: read data while selected, write on the rising edge of we_n.
    assign dq_i0 = (!ce_n0 && !oe_n0) ? mem0[sram_addr0[3:0]] : 32'h0;
    assign dq_i1 = (!ce_n1 && !oe_n1) ? mem1[sram_addr1[3:0]] : 32'h0;

    // Byte-lane write into model 0.
    always @(posedge we_n0) begin
        if (ce_n0 === 1'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_n0[b] === 1'b0) mem0[sram_addr0[3:0]][8*b +: 8] <= dq_o0[8*b +: 8];
            end
        end
    end

    // Byte-lane write into model 1.
    always @(posedge we_n1) begin
        if (ce_n1 === 1'b0) begin
            for (int b = 0; b < 4; b++) begin
                if (be_n1[b] === 1'b0) mem1[sram_addr1[3:0]][8*b +: 8] <= dq_o1[8*b +: 8];
            end
        end
    end

    // Issue one request on instance 0 and measure it cycle by cycle until stall drops.
    task automatic do_access0(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input logic [3:0] exp_be_n);
        int n;
        @(negedge clk);
        bus0.mem_access_addr    = a;
        bus0.mem_access_data_o  = d;
        bus0.mem_access_byte_en = be;
        bus0.mem_access_read    = r;
        bus0.mem_access_write   = w;
        #1;
        m_stall = 0; m_oe = 0; m_we = 0; m_dqoe = 0; m_be_bad = 0;
        m_addr = '0; m_dq = '0; m_data_done = '0; m_timeout = 1'b1;
        n = 0;
        while (n < 40) begin
            if (bus0.stall) m_stall++;
            if (!oe_n0) m_oe++;
            if (!we_n0) m_we++;
            if (dq_oe0) begin
                m_dqoe++;
                m_dq = dq_o0;
                if (be_n0 !== exp_be_n) m_be_bad++;
            end
            if (!ce_n0) m_addr = sram_addr0;
            if (!bus0.stall) begin
                m_timeout   = 1'b0;
                m_data_done = bus0.mem_access_data_i;
                break;
            end
            @(negedge clk);
            #1;
            n++;
        end
        bus0.mem_access_read  = 1'b0;
        bus0.mem_access_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.mem_access_read = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({ce_n0, oe_n0, we_n0, be_n0, dq_oe0} !== 8'b1111_1110) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b expected %b", {ce_n0, oe_n0, we_n0, be_n0, dq_oe0}, 8'b1111_1110);
        end
        checks++;
        if ({sram_addr0, dq_o0, bus0.mem_access_data_i} !== 84'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: addr %h dq_o %h data_i %h expected all zero", sram_addr0, dq_o0, bus0.mem_access_data_i);
        end
        checks++;
        if (bus0.stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_stall: got %b expected 0", bus0.stall);
        end
        bus0.mem_access_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        do_access0(1'b0, 1'b1, 32'h0000_0104, 32'hDEADBEEF, 4'b1111, 4'b0000);
        checks++;
        if (m_timeout) begin errors++; $display("[TB] FAIL write_timeout: stall never dropped"); end
        checks++;
        if (m_addr !== 20'h00041) begin errors++; $display("[TB] FAIL write_addr: got %h expected 00041", m_addr); end
        checks++;
        if (m_we != 2) begin errors++; $display("[TB] FAIL write_we_cycles: got %0d expected 2", m_we); end
        checks++;
        if (m_dqoe != 4) begin errors++; $display("[TB] FAIL write_dqoe_cycles: got %0d expected 4", m_dqoe); end
        checks++;
        if (m_stall != 5) begin errors++; $display("[TB] FAIL write_stall_cycles: got %0d expected 5", m_stall); end
        checks++;
        if (m_dq !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_dq: got %h expected deadbeef", m_dq); end
        checks++;
        if (m_be_bad != 0) begin errors++; $display("[TB] FAIL write_be: %0d cycles with be_n not 0000", m_be_bad); end
        checks++;
        if (mem0[1] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_mem: got %h expected deadbeef", mem0[1]); end
    endtask

    task automatic test_read();
        do_access0(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'b0000, 4'b1111);
        checks++;
        if (m_timeout) begin errors++; $display("[TB] FAIL read_timeout: stall never dropped"); end
        checks++;
        if (m_oe != 2) begin errors++; $display("[TB] FAIL read_oe_cycles: got %0d expected 2", m_oe); end
        checks++;
        if (m_stall != 3) begin errors++; $display("[TB] FAIL read_stall_cycles: got %0d expected 3", m_stall); end
        checks++;
        if (m_data_done !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", m_data_done); end
        @(negedge clk);
        #1;
        checks++;
        if (bus0.stall !== 1'b0 || bus0.mem_access_data_i !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_after_idle: stall %b data %h expected 0 deadbeef", bus0.stall, bus0.mem_access_data_i);
        end
    endtask

    task automatic test_byte_write();
        do_access0(1'b0, 1'b1, 32'h0000_0106, 32'h5A5A5A5A, 4'b0100, 4'b1011);
        checks++;
        if (m_timeout || m_stall != 5) begin errors++; $display("[TB] FAIL byte_stall: got %0d expected 5", m_stall); end
        checks++;
        if (m_be_bad != 0 || m_dqoe != 4) begin
            errors++;
            $display("[TB] FAIL byte_be: %0d bad be_n cycles over %0d dq_oe cycles, expected 0 over 4", m_be_bad, m_dqoe);
        end
        checks++;
        if (mem0[1] !== 32'hDE5ABEEF) begin errors++; $display("[TB] FAIL byte_mem: got %h expected de5abeef", mem0[1]); end
        checks++;
        if (bus0.mem_access_data_i !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL byte_data_hold: got %h expected deadbeef", bus0.mem_access_data_i);
        end
    endtask

    task automatic test_read_write_conflict();
        do_access0(1'b1, 1'b1, 32'h0000_0104, 32'h12345678, 4'b1111, 4'b1111);
        checks++;
        if (m_we != 0) begin errors++; $display("[TB] FAIL conflict_we: got %0d we_n low cycles expected 0", m_we); end
        checks++;
        if (m_oe != 2 || m_stall != 3) begin
            errors++;
            $display("[TB] FAIL conflict_read: oe %0d stall %0d expected 2 3", m_oe, m_stall);
        end
        checks++;
        if (m_data_done !== 32'hDE5ABEEF) begin errors++; $display("[TB] FAIL conflict_data: got %h expected de5abeef", m_data_done); end
        checks++;
        if (mem0[1] !== 32'hDE5ABEEF) begin errors++; $display("[TB] FAIL conflict_mem: got %h expected de5abeef", mem0[1]); end
    endtask

    task automatic test_reset_mid_write();
        int n;
        @(negedge clk);
        bus0.mem_access_addr    = 32'h0000_0208;
        bus0.mem_access_data_o  = 32'h11111111;
        bus0.mem_access_byte_en = 4'b1111;
        bus0.mem_access_write   = 1'b1;
        n = 0;
        while (we_n0 !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("[TB] FAIL midreset_timeout: we_n never went low"); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({we_n0, dq_oe0, bus0.stall} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: we_n/dq_oe/stall got %b expected 100", {we_n0, dq_oe0, bus0.stall});
        end
        checks++;
        if (bus0.mem_access_data_i !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_data: got %h expected 0", bus0.mem_access_data_i);
        end
        bus0.mem_access_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access0(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'b0000, 4'b1111);
        checks++;
        if (m_timeout || m_stall != 3 || m_oe != 2) begin
            errors++;
            $display("[TB] FAIL midreset_next: stall %0d oe %0d expected 3 2", m_stall, m_oe);
        end
        checks++;
        if (m_data_done !== 32'hDE5ABEEF) begin errors++; $display("[TB] FAIL midreset_read: got %h expected de5abeef", m_data_done); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] stall_log;
        logic [10:0] oe_log;
        logic [10:0] we_log;
        stall_log = '0; oe_log = '0; we_log = '0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            bus1.mem_access_read    = (c <= 1);
            bus1.mem_access_write   = (c >= 3) && (c <= 8);
            bus1.mem_access_addr    = (c <= 1) ? 32'h0000_0104 : 32'h0000_0108;
            bus1.mem_access_data_o  = 32'h0BADC0DE;
            bus1.mem_access_byte_en = 4'b1111;
            #1;
            stall_log[c] = bus1.stall;
            oe_log[c]    = ~oe_n1;
            we_log[c]    = ~we_n1;
        end
        bus1.mem_access_read  = 1'b0;
        bus1.mem_access_write = 1'b0;
        checks++;
        if (stall_log !== 11'b00111111011) begin errors++; $display("[TB] FAIL b2b_stall: got %b expected 00111111011", stall_log); end
        checks++;
        if (oe_log !== 11'b00000000010) begin errors++; $display("[TB] FAIL b2b_oe: got %b expected 00000000010", oe_log); end
        checks++;
        if (we_log !== 11'b00011100000) begin errors++; $display("[TB] FAIL b2b_we: got %b expected 00011100000", we_log); end
        checks++;
        if (bus1.mem_access_data_i !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_rdata: got %h expected cafef00d", bus1.mem_access_data_i); end
        checks++;
        if (mem1[2] !== 32'h0BADC0DE) begin errors++; $display("[TB] FAIL b2b_mem: got %h expected 0badc0de", mem1[2]); end
    endtask

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 32'h0;
            mem1[i] = 32'h0;
        end
        mem1[1] = 32'hCAFEF00D;
        bus0.mem_access_addr = '0; bus0.mem_access_data_o = '0; bus0.mem_access_byte_en = '0;
        bus0.mem_access_read = 1'b0; bus0.mem_access_write = 1'b0;
        bus1.mem_access_addr = '0; bus1.mem_access_data_o = '0; bus1.mem_access_byte_en = '0;
        bus1.mem_access_read = 1'b0; bus1.mem_access_write = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_byte_write();
        test_read_write_conflict();
        test_reset_mid_write();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
